// File: rtl/gray_counter.sv
// Up/down counter holding its count in binary and Gray code side by side, both
// registered, with parallel load (binary or Gray), wrap/saturate ends and a terminal-count pulse.
module gray_counter #(
  parameter int WIDTH    = 5,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             tc_nxt;
  logic             at_end;

  // MSB passes straight through; each lower bit folds in everything above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign at_end = up_dn ? (bin_out == MAX_COUNT) : (bin_out == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    bin_nxt = bin_out;
    tc_nxt  = 1'b0;
    if (load) begin
      bin_nxt = load_gray ? gray_to_bin(load_val) : load_val;
    end else if (en) begin
      tc_nxt = at_end;
      if (!(at_end && SATURATE)) begin
        bin_nxt = up_dn ? bin_out + WIDTH'(1) : bin_out - WIDTH'(1);
      end
    end
  end

  // Gray is encoded from the next binary value so gray_out leaves a flop directly.
  assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all three registers updating on the same edge.
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      tc       <= 1'b0;
    end else begin
      bin_out  <= bin_nxt;
      gray_out <= gray_nxt;
      tc       <= tc_nxt;
    end
  end

endmodule
